// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX serializer between NUM_REQ byte sources.
// Sequences TX_DV, waits for TX_Done, inserts an optional gap and aborts via watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GAP_CLKS     = 0,
    parameter int unsigned TIMEOUT_CLKS = 4096,
    // Reset value of the sent counter; nonzero only to reach the wrap point quickly.
    parameter logic [15:0] SENT_INIT    = 16'h0000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Active,
    input  logic                   i_TX_Done,
    output logic                   o_Busy,
    output logic                   o_Timeout,
    output logic [15:0]            o_Sent_Count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int unsigned GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [7:0]          byte_q, byte_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [7:0]          req_bytes [NUM_REQ];
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    int unsigned         cand;
    logic [NUM_REQ-1:0]  grant_oh;

    // Busy status from the serializer is informational only.
    logic unused_tx_active;
    assign unused_tx_active = i_TX_Active;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
        assign req_bytes[k] = i_Req_Byte[8*k+7:8*k];
    end

    // First requester at or after last_q+1, wrapping; requester 0 wins right after reset.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_q) + off) % NUM_REQ;
            if (!pick_found && i_Req[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        grant_oh         = '0;
        grant_oh[gidx_q] = 1'b1;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            byte_q  <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            cnt_q   <= SENT_INIT;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gidx_d    = gidx_q;
        last_d    = last_q;
        byte_d    = byte_q;
        wd_d      = wd_q;
        gap_d     = gap_q;
        cnt_d     = cnt_q;
        o_TX_DV   = 1'b0;
        o_Ack     = '0;
        o_Grant   = '0;
        o_Timeout = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gidx_d  = pick_idx;
                    byte_d  = req_bytes[pick_idx];
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_TX_DV = 1'b1;
                o_Ack   = grant_oh;
                o_Grant = grant_oh;
                last_d  = gidx_q;
                wd_d    = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                o_Grant = grant_oh;
                // Done takes precedence over a watchdog expiry in the same clock.
                if (i_TX_Done) begin
                    cnt_d   = cnt_q + 16'd1;
                    gap_d   = '0;
                    state_d = (GAP_CLKS == 0) ? ST_IDLE : ST_GAP;
                end else if (TIMEOUT_CLKS != 0 && wd_q == WD_W'(TIMEOUT_CLKS - 1)) begin
                    o_Timeout = 1'b1;
                    state_d   = ST_IDLE;
                end else if (TIMEOUT_CLKS != 0) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_GAP: begin
                o_Grant = grant_oh;
                if (gap_q == GAP_W'(GAP_CLKS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_TX_Byte    = byte_q;
    assign o_Busy       = (state_q != ST_IDLE);
    assign o_Sent_Count = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model checked every cycle, plus
// literal expectations for ordering, latency, gap spacing, watchdog and counter wrap.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int GAP = 5;
    localparam int TMO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 requesters, 5-clock gap, 64-clock watchdog.
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  rb [NR];
    logic [31:0] req_byte;
    logic        done;
    logic        stray_done;
    logic        tx_active;
    logic [3:0]  a_ack, a_grant;
    logic        a_dv, a_busy, a_to;
    logic [7:0]  a_byte;
    logic [15:0] a_cnt;

    assign req_byte  = {rb[3], rb[2], rb[1], rb[0]};
    assign tx_active = a_busy;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Req_Byte(req_byte),
        .o_Ack(a_ack), .o_Grant(a_grant), .o_TX_DV(a_dv), .o_TX_Byte(a_byte),
        .i_TX_Active(tx_active), .i_TX_Done(done), .o_Busy(a_busy),
        .o_Timeout(a_to), .o_Sent_Count(a_cnt)
    );

    // Instance B: 2 requesters, no gap, counter starting at 0xFFFF.
    logic        rst_b;
    logic [1:0]  req_b;
    logic [15:0] byte_b;
    logic        done_b;
    logic [1:0]  b_ack, b_grant;
    logic        b_dv, b_busy, b_to;
    logic [7:0]  b_byte;
    logic [15:0] b_cnt;

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CLKS(0), .TIMEOUT_CLKS(TMO), .SENT_INIT(16'hFFFF)) dut_b (
        .i_Clk(clk), .i_Rst(rst_b), .i_Req(req_b), .i_Req_Byte(byte_b),
        .o_Ack(b_ack), .o_Grant(b_grant), .o_TX_DV(b_dv), .o_TX_Byte(b_byte),
        .i_TX_Active(1'b0), .i_TX_Done(done_b), .o_Busy(b_busy),
        .o_Timeout(b_to), .o_Sent_Count(b_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer stub: Done pulses stub_dly clocks after each TX_DV unless disabled.
    int stub_dly = 10;
    bit stub_en  = 1'b1;
    int done_at  = -1;

    always @(negedge clk) begin
        if (rst) done_at = -1;
        else if (a_dv && stub_en) done_at = cyc + stub_dly;
    end

    always @(posedge clk) begin
        #1;
        done = (cyc == done_at) || stray_done;
    end

    // Model state: owner of the serializer, clocks since its TX_DV, gap clocks left.
    int          m_owner = -1;
    int          m_since = 0;
    int          m_gap   = -1;
    logic [1:0]  m_last  = 2'd3;
    logic [7:0]  m_byte  = 8'h00;
    logic [15:0] m_cnt   = 16'h0000;

    logic [7:0] dv_bytes [$];
    int         dv_cycs  [$];
    int         to_cycs  [$];

    always @(negedge clk) begin
        logic [3:0] e_grant;
        logic [3:0] e_ack;
        logic       e_dv;
        logic       e_busy;
        logic       e_to;
        logic [1:0] c;
        bit         waiting;
        bit         picked;

        if (rst) begin
            m_owner = -1;
            m_since = 0;
            m_gap   = -1;
            m_last  = 2'd3;
            m_byte  = 8'h00;
            m_cnt   = 16'h0000;
        end

        e_busy  = (m_owner >= 0);
        e_grant = e_busy ? 4'(1 << m_owner) : 4'b0000;
        e_dv    = e_busy && (m_since == 0);
        e_ack   = e_dv ? e_grant : 4'b0000;
        waiting = e_busy && (m_since >= 1) && (m_gap < 0);
        e_to    = waiting && !done && (m_since == TMO);

        chk("busy",    32'(a_busy),  32'(e_busy));
        chk("grant",   32'(a_grant), 32'(e_grant));
        chk("ack",     32'(a_ack),   32'(e_ack));
        chk("tx_dv",   32'(a_dv),    32'(e_dv));
        chk("tx_byte", 32'(a_byte),  32'(m_byte));
        chk("timeout", 32'(a_to),    32'(e_to));
        chk("sent",    32'(a_cnt),   32'(m_cnt));

        if (a_dv) begin
            dv_bytes.push_back(a_byte);
            dv_cycs.push_back(cyc);
        end
        if (a_to) to_cycs.push_back(cyc);

        if (!rst) begin
            if (m_owner < 0) begin
                picked = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    c = 2'(32'(m_last) + k);
                    if (!picked && req[c]) begin
                        picked  = 1'b1;
                        m_owner = int'(c);
                        m_last  = c;
                        m_byte  = rb[c];
                        m_since = 0;
                        m_gap   = -1;
                    end
                end
            end else if (m_since == 0) begin
                m_since = 1;
            end else if (m_gap < 0) begin
                if (done) begin
                    m_cnt = m_cnt + 16'd1;
                    if (GAP == 0) m_owner = -1;
                    else m_gap = GAP;
                end else if (m_since == TMO) begin
                    m_owner = -1;
                end else begin
                    m_since++;
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_owner = -1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dv(input int target);
        int n = 0;
        while (dv_cycs.size() < target && n < 300) begin
            tick(1);
            n++;
        end
        chk("dv_arrival", 32'(dv_cycs.size() >= target), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (a_busy && n < 300) begin
            tick(1);
            n++;
        end
        chk("idle_reached", 32'(a_busy), 32'd0);
    endtask

    task automatic clear_logs();
        dv_bytes.delete();
        dv_cycs.delete();
        to_cycs.delete();
    endtask

    logic [7:0] exp_rr [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        rst        = 1'b1;
        req        = 4'b0000;
        rb         = '{8'h00, 8'h00, 8'h00, 8'h00};
        stray_done = 1'b0;
        done       = 1'b0;
        rst_b      = 1'b1;
        req_b      = 2'b00;
        byte_b     = 16'h0000;
        done_b     = 1'b0;

        // Reset state and single-byte latency.
        tick(2);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_grant", 32'(a_grant), 32'd0);
        chk("rst_byte",  32'(a_byte),  32'd0);
        chk("rst_cnt",   32'(a_cnt),   32'd0);
        rst = 1'b0;
        tick(1);
        req   = 4'b0001;
        rb[0] = 8'hA5;
        chk("t1_no_dv_yet", 32'(a_dv), 32'd0);
        tick(1);
        chk("t1_dv",   32'(a_dv),   32'd1);
        chk("t1_ack",  32'(a_ack),  32'h1);
        chk("t1_byte", 32'(a_byte), 32'hA5);
        req = 4'b0000;
        wait_idle();
        chk("t1_cnt",   32'(a_cnt),   32'd1);
        chk("t1_grant", 32'(a_grant), 32'd0);

        // Fairness with all four requesting; gap spacing.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clear_logs();
        rb  = '{8'h11, 8'h22, 8'h33, 8'h44};
        req = 4'b1111;
        wait_dv(5);
        req = 4'b0000;
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            if (i < dv_bytes.size()) chk("t2_order", 32'(dv_bytes[i]), 32'(exp_rr[i]));
            else chk("t2_order_missing", 32'(i), 32'(dv_bytes.size()));
        end
        chk("t2_dv_count", 32'(dv_cycs.size()), 32'd5);
        if (dv_cycs.size() >= 2)
            chk("t4_dv_spacing", 32'(dv_cycs[1] - dv_cycs[0]), 32'd17);
        chk("t2_cnt", 32'(a_cnt), 32'd5);

        // Late arrival waits; a request withdrawn before grant is never served.
        clear_logs();
        req = 4'b0100;
        wait_dv(1);
        req = 4'b1010;
        tick(2);
        req = 4'b0010;
        wait_dv(2);
        req = 4'b0000;
        wait_idle();
        chk("t3_size", 32'(dv_bytes.size()), 32'd2);
        if (dv_bytes.size() == 2) begin
            chk("t3_first",  32'(dv_bytes[0]), 32'h33);
            chk("t3_second", 32'(dv_bytes[1]), 32'h22);
        end
        chk("t3_cnt", 32'(a_cnt), 32'd7);

        // Done outside a transfer is ignored.
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        tick(2);
        chk("stray_cnt", 32'(a_cnt), 32'd7);

        // Watchdog expiry, then Done coinciding with the expiry clock.
        clear_logs();
        stub_en = 1'b0;
        req     = 4'b0001;
        wait_dv(1);
        req = 4'b0000;
        wait_idle();
        chk("t5_to_count", 32'(to_cycs.size()), 32'd1);
        if (to_cycs.size() == 1 && dv_cycs.size() == 1)
            chk("t5_to_delay", 32'(to_cycs[0] - dv_cycs[0]), 32'd64);
        chk("t5_cnt_held", 32'(a_cnt), 32'd7);
        stub_en  = 1'b1;
        stub_dly = 64;
        req      = 4'b0001;
        wait_dv(2);
        req = 4'b0000;
        wait_idle();
        chk("t5_done_wins", 32'(to_cycs.size()), 32'd1);
        chk("t5_cnt_inc",   32'(a_cnt),          32'd8);

        // Reset during WAIT_DONE; next grant restarts at requester 0.
        stub_dly = 10;
        req      = 4'b0100;
        wait_dv(3);
        req = 4'b0000;
        tick(3);
        rst = 1'b1;
        #1;
        chk("t6_busy",  32'(a_busy),  32'd0);
        chk("t6_grant", 32'(a_grant), 32'd0);
        chk("t6_dv",    32'(a_dv),    32'd0);
        chk("t6_byte",  32'(a_byte),  32'd0);
        chk("t6_cnt",   32'(a_cnt),   32'd0);
        tick(1);
        clear_logs();
        req = 4'b1111;
        rst = 1'b0;
        wait_dv(1);
        req = 4'b0000;
        if (dv_bytes.size() >= 1) chk("t6_first_byte", 32'(dv_bytes[0]), 32'h11);
        wait_idle();

        // Counter wrap and zero-gap spacing on instance B.
        tick(1);
        chk("b_rst_cnt",  32'(b_cnt),  32'hFFFF);
        chk("b_rst_busy", 32'(b_busy), 32'd0);
        rst_b  = 1'b0;
        tick(1);
        req_b  = 2'b11;
        byte_b = {8'hB2, 8'hB1};
        tick(1);
        chk("b_dv0",   32'(b_dv),   32'd1);
        chk("b_ack0",  32'(b_ack),  32'h1);
        chk("b_byte0", 32'(b_byte), 32'hB1);
        done_b = 1'b1;
        tick(1);
        chk("b_wait_dv",    32'(b_dv),    32'd0);
        chk("b_wait_grant", 32'(b_grant), 32'h1);
        tick(1);
        done_b = 1'b0;
        chk("b_wrap_cnt", 32'(b_cnt),   32'h0000);
        chk("b_idle",     32'(b_busy),  32'd0);
        chk("b_no_grant", 32'(b_grant), 32'd0);
        tick(1);
        chk("b_dv1",   32'(b_dv),   32'd1);
        chk("b_ack1",  32'(b_ack),  32'h2);
        chk("b_byte1", 32'(b_byte), 32'hB2);
        chk("b_no_to", 32'(b_to),   32'd0);
        req_b = 2'b00;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
